apb_slave_mem: RTL and testbench

//  APB completer: a register-file memory behind one psel line of the codebase APB master.

---
 rtl/apb_slave_mem_pkg.sv | 27 ++
 rtl/apb_slave_mem_if.sv | 44 ++++
 rtl/apb_slave_mem.sv | 125 ++++++++++++
 tb/tb_apb_slave_mem.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_mem_pkg.sv
// Shared definitions for the APB register-file completer: bus widths,
// wait-counter sizing and the transfer-phase encoding that the bus master
// in this codebase uses as well.
package apb_slave_mem_pkg;

    // Default slave-local bus widths (bus address bit 8 is decoded by the master).
    localparam int APB_ADDR_WIDTH = 8;
    localparam int APB_DATA_WIDTH = 8;

    // The wait counter is 4 bits, so at most 15 stretched ACCESS cycles.
    localparam int WAIT_CNT_WIDTH  = 4;
    localparam int WAIT_STATES_MAX = (1 << WAIT_CNT_WIDTH) - 1;

    // Transfer phases. The master calls the ACCESS phase ENABLE; the
    // encoding is the same value (2'b10).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apbState_t;

    // Number of index bits needed to address a memory of the given depth.
    function automatic int memIndexWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the codebase master and one completer.
// The master drives select/enable/address/data; the completer answers
// with ready, read data and the error flag.
interface apb_slave_mem_if
    import apb_slave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH
);

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    // Requester side of the bus.
    modport master (
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        input  pready,
        input  prdata,
        input  pslverr
    );

    // Completer side of the bus.
    modport slave (
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        output pready,
        output prdata,
        output pslverr
    );

endinterface

// File: rtl/apb_slave_mem.sv
// APB completer backed by a reset-clearable flop-array register file.
// The transfer is captured while the bus is in SETUP, the ACCESS phase is
// stretched by WAIT_STATES cycles of pready low, and addresses at or beyond
// MEM_DEPTH complete with pslverr instead of touching memory.
module apb_slave_mem
    import apb_slave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic           pclk,
    input  logic           presetn,
    apb_slave_mem_if.slave bus
);

    localparam int IDX_WIDTH = memIndexWidth(MEM_DEPTH);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LIMIT = WAIT_CNT_WIDTH'(WAIT_STATES);

    // The wait counter cannot represent more than 15 stretched cycles, and
    // the memory index is a slice of the slave-local address.
    if (WAIT_STATES < 0 || WAIT_STATES > WAIT_STATES_MAX) begin : gBadWaitStates
        $error("apb_slave_mem: WAIT_STATES must be in 0..15");
    end
    if (IDX_WIDTH > ADDR_WIDTH) begin : gBadDepth
        $error("apb_slave_mem: MEM_DEPTH exceeds the slave address space");
    end

    apbState_t                 state_q;
    apbState_t                 phase;
    logic [WAIT_CNT_WIDTH-1:0] waitCnt_q;
    logic [IDX_WIDTH-1:0]      addr_q;
    logic                      wr_q;
    logic [DATA_WIDTH-1:0]     wd_q;
    logic                      err_q;
    logic [DATA_WIDTH-1:0]     mem_q [MEM_DEPTH];

    logic setupErr;
    logic complete;
    logic commit;

    // An address is in range only below MEM_DEPTH; one extra bit keeps the
    // compare exact even when MEM_DEPTH equals the full address space.
    assign setupErr = ({1'b0, bus.paddr} >= (ADDR_WIDTH + 1)'(MEM_DEPTH));

    // The master drops psel and zeroes paddr/pwdata once it enters ENABLE,
    // so the transfer must be captured on the edge that closes the bus SETUP
    // cycle. The registered state only records IDLE or ACCESS; the SETUP
    // phase is recognised from the bus itself whenever no ACCESS is under
    // way. This is also what lets a completion flow straight into the next
    // SETUP with no idle cycle in between. penable without a preceding
    // SETUP is simply not a SETUP, so it is ignored.
    always_comb begin
        phase = ST_IDLE;
        if (state_q == ST_ACCESS) begin
            phase = ST_ACCESS;
        end else if (bus.psel && !bus.penable) begin
            phase = ST_SETUP;
        end
    end

    // Completion: ACCESS still enabled and all wait states used up.
    // Writes only land when the captured address was in range.
    assign complete = (state_q == ST_ACCESS) && bus.penable && (waitCnt_q == WAIT_LIMIT);
    assign commit   = complete && wr_q && !err_q;

    // Transfer FSM: capture in SETUP, count wait states in ACCESS, drop the
    // transfer silently if penable falls early. During ACCESS only the
    // captured copies are used; the live bus address/data are ignored.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            waitCnt_q <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            case (phase)
                ST_SETUP: begin
                    addr_q    <= bus.paddr[IDX_WIDTH-1:0];
                    wr_q      <= bus.pwrite;
                    wd_q      <= bus.pwdata;
                    err_q     <= setupErr;
                    waitCnt_q <= '0;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!bus.penable) begin
                        state_q <= ST_IDLE;
                    end else if (waitCnt_q != WAIT_LIMIT) begin
                        waitCnt_q <= waitCnt_q + WAIT_CNT_WIDTH'(1);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Register file: cleared by reset, written on the edge that ends a
    // successful write completion. Because this happens before the next
    // SETUP is captured, a back-to-back read sees the new value.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit) begin
            mem_q[addr_q] <= wd_q;
        end
    end

    // Responses are combinational from the ACCESS state so that pready
    // appears in the completion cycle itself. Read data is forced to zero
    // outside a successful read completion, including errored reads.
    assign bus.pready  = complete;
    assign bus.pslverr = complete && err_q;
    assign bus.prdata  = (complete && !wr_q && !err_q) ? mem_q[addr_q] : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with one wait state and one
// with none, sharing a clock, reset and the enable/address/data lines, each
// with its own select. The bus is driven like the codebase master, which
// drops psel and zeroes paddr/pwdata during ENABLE.
module tb_apb_slave_mem;

    logic       pclk;
    logic       presetn;
    logic       psel0;
    logic       psel1;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;

    int checks   = 0;
    int failures = 0;

    apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus1 ();
    apb_slave_mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus0 ();

    assign bus1.psel    = psel1;
    assign bus1.penable = penable;
    assign bus1.pwrite  = pwrite;
    assign bus1.paddr   = paddr;
    assign bus1.pwdata  = pwdata;

    assign bus0.psel    = psel0;
    assign bus0.penable = penable;
    assign bus0.pwrite  = pwrite;
    assign bus0.paddr   = paddr;
    assign bus0.pwdata  = pwdata;

    apb_slave_mem #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .MEM_DEPTH  (64),
        .WAIT_STATES(1)
    ) dut1 (
        .pclk   (pclk),
        .presetn(presetn),
        .bus    (bus1)
    );

    apb_slave_mem #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .MEM_DEPTH  (64),
        .WAIT_STATES(0)
    ) dut0 (
        .pclk   (pclk),
        .presetn(presetn),
        .bus    (bus0)
    );

    // Free-running bus clock, 10 time units per period.
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Hard stop in case something stalls beyond every bounded wait.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic readyOf(input int tgt);
        return (tgt == 1) ? bus1.pready : bus0.pready;
    endfunction

    function automatic logic [7:0] rdataOf(input int tgt);
        return (tgt == 1) ? bus1.prdata : bus0.prdata;
    endfunction

    function automatic logic errOf(input int tgt);
        return (tgt == 1) ? bus1.pslverr : bus0.pslverr;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Park the bus for n cycles.
    task automatic idleCycles(input int n);
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // One complete transfer to instance tgt, entered just after a rising
    // edge. Checks the completion cycle number (wait states + 1), the read
    // data and the error flag. Returns just after the edge that ends the
    // completion cycle with penable low, so an immediate next call is a
    // back-to-back transfer.
    task automatic applyStimulus(input string tag, input int tgt, input logic wr,
                                 input logic [7:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] expRdata, input logic expErr);
        int         ws;
        int         cyc;
        logic       done;
        logic [7:0] gotRdata;
        logic       gotErr;
        ws       = (tgt == 1) ? 1 : 0;
        done     = 1'b0;
        cyc      = 0;
        gotRdata = 8'hEE;
        gotErr   = 1'bx;
        psel0    = (tgt == 0);
        psel1    = (tgt == 1);
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = addr;
        pwdata   = wdata;
        @(posedge pclk);
        #1;
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b1;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        while (!done && cyc < 20) begin
            @(negedge pclk);
            cyc++;
            if (readyOf(tgt)) begin
                done     = 1'b1;
                gotRdata = rdataOf(tgt);
                gotErr   = errOf(tgt);
            end
            @(posedge pclk);
            #1;
        end
        penable = 1'b0;
        pwrite  = 1'b0;
        checkOutput({tag, "_lat"},   done ? cyc : 99, ws + 1);
        checkOutput({tag, "_rdata"}, {24'h0, gotRdata}, {24'h0, expRdata});
        checkOutput({tag, "_err"},   {31'h0, gotErr},   {31'h0, expErr});
    endtask

    initial begin
        presetn = 1'b0;
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;

        // Reset state of both instances.
        @(negedge pclk);
        checkOutput("rst_pready1",  {31'h0, bus1.pready},  0);
        checkOutput("rst_pslverr1", {31'h0, bus1.pslverr}, 0);
        checkOutput("rst_prdata1",  {24'h0, bus1.prdata},  0);
        checkOutput("rst_pready0",  {31'h0, bus0.pready},  0);
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk);
        #1;

        // Test 1: reset lands in the middle of a stretched write.
        psel1  = 1'b1;
        pwrite = 1'b1;
        paddr  = 8'h03;
        pwdata = 8'hA5;
        @(posedge pclk);
        #1;
        psel1   = 1'b0;
        penable = 1'b1;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        @(negedge pclk);
        checkOutput("t1_waitCycle", {31'h0, bus1.pready}, 0);
        #1;
        presetn = 1'b0;
        #1;
        checkOutput("t1_rstPready",  {31'h0, bus1.pready},  0);
        checkOutput("t1_rstPslverr", {31'h0, bus1.pslverr}, 0);
        checkOutput("t1_rstPrdata",  {24'h0, bus1.prdata},  0);
        @(posedge pclk);
        #1;
        @(negedge pclk);
        checkOutput("t1_heldInReset", {31'h0, bus1.pready}, 0);
        #1;
        presetn = 1'b1;
        idleCycles(1);
        applyStimulus("t1_readBack", 1, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0);
        idleCycles(1);

        // Test 2: write then read with one wait state.
        applyStimulus("t2_write", 1, 1'b1, 8'h10, 8'h3C, 8'h00, 1'b0);
        idleCycles(1);
        applyStimulus("t2_read",  1, 1'b0, 8'h10, 8'h00, 8'h3C, 1'b0);
        idleCycles(1);

        // Test 3: first address past the end, plus the aliasing word 0.
        applyStimulus("t3_errWrite", 1, 1'b1, 8'h40, 8'hFF, 8'h00, 1'b1);
        idleCycles(1);
        applyStimulus("t3_errRead",  1, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1);
        idleCycles(1);
        applyStimulus("t3_word0",    1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        applyStimulus("t3_lastWr",   1, 1'b1, 8'h3F, 8'hC3, 8'h00, 1'b0);
        applyStimulus("t3_lastRd",   1, 1'b0, 8'h3F, 8'h00, 8'hC3, 1'b0);
        idleCycles(1);

        // Test 4: back-to-back transfers with no idle cycle in between.
        applyStimulus("t4_wr1",  1, 1'b1, 8'h01, 8'h11, 8'h00, 1'b0);
        applyStimulus("t4_wr2",  1, 1'b1, 8'h02, 8'h22, 8'h00, 1'b0);
        applyStimulus("t4_rd1",  1, 1'b0, 8'h01, 8'h00, 8'h11, 1'b0);
        applyStimulus("t4_rd2",  1, 1'b0, 8'h02, 8'h00, 8'h22, 1'b0);
        applyStimulus("t4_wr5",  1, 1'b1, 8'h05, 8'h5A, 8'h00, 1'b0);
        applyStimulus("t4_raw5", 1, 1'b0, 8'h05, 8'h00, 8'h5A, 1'b0);
        idleCycles(1);

        // Test 5: penable dropped in ACCESS, then a stray enable.
        psel1  = 1'b1;
        pwrite = 1'b1;
        paddr  = 8'h07;
        pwdata = 8'h77;
        @(posedge pclk);
        #1;
        psel1   = 1'b0;
        penable = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            checkOutput("t5_abortIdle", {31'h0, bus1.pready}, 0);
            @(posedge pclk);
            #1;
        end
        penable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            checkOutput("t5_strayEnable", {31'h0, bus1.pready}, 0);
            @(posedge pclk);
            #1;
        end
        idleCycles(1);
        applyStimulus("t5_read7", 1, 1'b0, 8'h07, 8'h00, 8'h00, 1'b0);
        idleCycles(1);

        // Test 6: zero-wait-state instance.
        applyStimulus("t6_read0", 0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        idleCycles(1);
        psel0   = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            checkOutput("t6_noSetupEnable", {31'h0, bus0.pready}, 0);
            @(posedge pclk);
            #1;
        end
        idleCycles(1);
        applyStimulus("t6_write3F", 0, 1'b1, 8'h3F, 8'h9C, 8'h00, 1'b0);
        applyStimulus("t6_read3F",  0, 1'b0, 8'h3F, 8'h00, 8'h9C, 1'b0);
        applyStimulus("t6_err80",   0, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1);
        applyStimulus("t6_isolate", 1, 1'b0, 8'h3F, 8'h00, 8'hC3, 1'b0);
        idleCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
